result_writeback_unit: RTL and testbench

RESULT_WRITEBACK_UNIT -- requirements
Module: result_writeback_unit

---
 rtl/result_writeback_unit.sv | 136 +++++++++++++
 tb/tb_result_writeback_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_unit.sv
// Result writeback stage: single-cycle ALU/shifter writes, plus waits for multiplier/divider
// completion with a 64-cycle timeout. Define RESULT_FORWARD_EN to add operand-bypass outputs.
module result_writeback_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [2:0]  result_sel,
    input  logic [4:0]  dest_reg,
    input  logic [31:0] alu_result,
    input  logic [31:0] shifter_result,
    input  logic [31:0] mul_result,
    input  logic [31:0] div_result,
    input  logic        mul_done,
    input  logic        div_done,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic        timeout_err
`ifdef RESULT_FORWARD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data
`endif
);

    // state    | meaning
    // IDLE     | accepting result_sel; ALU/shifter results written next cycle
    // WAIT_MUL | waiting for mul_done, destination index held in dest_q
    // WAIT_DIV | waiting for div_done, destination index held in dest_q
    typedef enum logic [1:0] {IDLE, WAIT_MUL, WAIT_DIV} state_t;

    localparam logic [2:0] SEL_ALU = 3'd1;
    localparam logic [2:0] SEL_DIV = 3'd2;
    localparam logic [2:0] SEL_MUL = 3'd3;
    localparam logic [2:0] SEL_SHF = 3'd4;

    state_t      state, state_next;
    logic [5:0]  wait_cnt, wait_cnt_next;
    logic [4:0]  dest_q, dest_q_next;
    logic        terr_next;
    logic        wr_req;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        we_next;
    logic [4:0]  waddr_next;
    logic [31:0] wdata_next;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        dest_q_next   = dest_q;
        terr_next     = timeout_err;
        wr_req        = 1'b0;
        wr_addr       = dest_reg;
        wr_data       = alu_result;

        case (state)
            IDLE: begin
                if (enable) begin
                    case (result_sel)
                        SEL_ALU: begin
                            wr_req  = 1'b1;
                            wr_data = alu_result;
                        end
                        SEL_SHF: begin
                            wr_req  = 1'b1;
                            wr_data = shifter_result;
                        end
                        SEL_MUL: begin
                            state_next    = WAIT_MUL;
                            wait_cnt_next = 6'd0;
                            dest_q_next   = dest_reg;
                        end
                        SEL_DIV: begin
                            state_next    = WAIT_DIV;
                            wait_cnt_next = 6'd0;
                            dest_q_next   = dest_reg;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_MUL, WAIT_DIV: begin
                wr_addr = dest_q;
                wr_data = (state == WAIT_MUL) ? mul_result : div_result;
                // A completion in the last counted cycle still beats the timeout.
                if ((state == WAIT_MUL) ? mul_done : div_done) begin
                    wr_req     = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == 6'd63) begin
                    terr_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 6'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Register 0 is hardwired; its writes are dropped and the write port holds.
        we_next    = wr_req && (wr_addr != 5'd0);
        waddr_next = we_next ? wr_addr : rf_waddr;
        wdata_next = we_next ? wr_data : rf_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 6'd0;
            dest_q      <= 5'd0;
            rf_we       <= 1'b0;
            rf_waddr    <= 5'd0;
            rf_wdata    <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            dest_q      <= dest_q_next;
            rf_we       <= we_next;
            rf_waddr    <= waddr_next;
            rf_wdata    <= wdata_next;
            timeout_err <= terr_next;
        end
    end

    assign busy = (state != IDLE);

`ifdef RESULT_FORWARD_EN
    assign fwd_valid = we_next && !reset;
    assign fwd_addr  = waddr_next;
    assign fwd_data  = wdata_next;
`endif

endmodule

// File: tb/tb_result_writeback_unit.sv
// Self-checking bench for result_writeback_unit: directed table, multi-cycle corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_result_writeback_unit;

    logic        clk = 1'b0;
    logic        reset, enable, mul_done, div_done;
    logic [2:0]  result_sel;
    logic [4:0]  dest_reg;
    logic [31:0] alu_result, shifter_result, mul_result, div_result;
    logic        rf_we, busy, timeout_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef RESULT_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    result_writeback_unit dut (
        .clk(clk), .reset(reset), .enable(enable), .result_sel(result_sel),
        .dest_reg(dest_reg), .alu_result(alu_result), .shifter_result(shifter_result),
        .mul_result(mul_result), .div_result(div_result), .mul_done(mul_done),
        .div_done(div_done), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .timeout_err(timeout_err)
`ifdef RESULT_FORWARD_EN
        , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b0; result_sel = 3'd0; dest_reg = 5'd0;
        alu_result = 32'd0; shifter_result = 32'd0; mul_result = 32'd0; div_result = 32'd0;
        mul_done = 1'b0; div_done = 1'b0;
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_unit;      // 0 none, 1 multiplier, 2 divider outstanding
    int          m_elapsed;   // wait cycles spent on the outstanding operation
    logic [4:0]  m_dest;
    logic        e_we, e_terr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    task automatic model_reset();
        m_unit = 0; m_elapsed = 0; m_dest = 5'd0;
        e_we = 1'b0; e_terr = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    endtask

    task automatic model_step();
        bit          wr;
        logic [4:0]  a;
        logic [31:0] d;
        wr = 0; a = 5'd0; d = 32'd0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_unit == 0) begin
            if (enable) begin
                if (result_sel == 3'd1) begin wr = 1; a = dest_reg; d = alu_result; end
                if (result_sel == 3'd4) begin wr = 1; a = dest_reg; d = shifter_result; end
                if (result_sel == 3'd3 || result_sel == 3'd2) begin
                    m_unit = (result_sel == 3'd3) ? 1 : 2;
                    m_elapsed = 0;
                    m_dest = dest_reg;
                end
            end
        end else begin
            m_elapsed++;
            if ((m_unit == 1 && mul_done) || (m_unit == 2 && div_done)) begin
                wr = 1; a = m_dest; d = (m_unit == 1) ? mul_result : div_result;
                m_unit = 0;
            end else if (m_elapsed == 64) begin
                e_terr = 1'b1;
                m_unit = 0;
            end
        end
        e_we = wr && (a != 5'd0);
        if (e_we) begin e_addr = a; e_data = d; end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        en;
        logic [2:0]  sel;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] shf;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    logic [4:0]  last_addr;
    logic [31:0] last_data;
    int          busy_cycles;

    initial begin
        vecs[0] = '{1'b1, 3'd1, 5'd5,  32'h1234_5678, 32'h0,          1'b1, 5'd5,  32'h1234_5678};
        vecs[1] = '{1'b1, 3'd0, 5'd9,  32'h1111_1111, 32'h2222_2222,  1'b0, 5'd0,  32'h0};
        vecs[2] = '{1'b1, 3'd4, 5'd3,  32'h0,         32'hAAAA_5555,  1'b1, 5'd3,  32'hAAAA_5555};
        vecs[3] = '{1'b0, 3'd1, 5'd6,  32'h6666_6666, 32'h0,          1'b0, 5'd0,  32'h0};
        vecs[4] = '{1'b1, 3'd4, 5'd0,  32'h0,         32'hFFFF_FFFF,  1'b0, 5'd0,  32'h0};
        vecs[5] = '{1'b1, 3'd5, 5'd8,  32'h5555_0000, 32'h0000_5555,  1'b0, 5'd0,  32'h0};
        vecs[6] = '{1'b1, 3'd7, 5'd10, 32'h7777_7777, 32'h7777_7777,  1'b0, 5'd0,  32'h0};
        vecs[7] = '{1'b1, 3'd1, 5'd31, 32'h0000_0000, 32'h0,          1'b1, 5'd31, 32'h0};
        vecs[8] = '{1'b1, 3'd1, 5'd0,  32'h0000_0001, 32'h0,          1'b0, 5'd0,  32'h0};

        idle_inputs();
        reset = 1'b1;
        step(); step();
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
`ifdef RESULT_FORWARD_EN
        chk("rst_fwd_valid", fwd_valid, 0);
`endif
        reset = 1'b0;
        step();

        last_addr = 5'd0; last_data = 32'd0;
        for (int i = 0; i < 9; i++) begin
            enable = vecs[i].en; result_sel = vecs[i].sel; dest_reg = vecs[i].dest;
            alu_result = vecs[i].alu; shifter_result = vecs[i].shf;
            if (vecs[i].exp_we) begin
                last_addr = vecs[i].exp_addr;
                last_data = vecs[i].exp_data;
            end
`ifdef RESULT_FORWARD_EN
            #1;
            chk($sformatf("tbl%0d_fwd_valid", i), fwd_valid, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                chk($sformatf("tbl%0d_fwd_addr", i), fwd_addr, last_addr);
                chk($sformatf("tbl%0d_fwd_data", i), fwd_data, last_data);
            end
`endif
            step();
            chk($sformatf("tbl%0d_we", i), rf_we, vecs[i].exp_we);
            chk($sformatf("tbl%0d_waddr", i), rf_waddr, last_addr);
            chk($sformatf("tbl%0d_wdata", i), rf_wdata, last_data);
            chk($sformatf("tbl%0d_busy", i), busy, 0);
        end
        idle_inputs();
        step();
        chk("tbl_tail_we", rf_we, 0);

        // Multiplier: done in the 11th wait cycle; other inputs are noise meant to be ignored.
        enable = 1'b1; result_sel = 3'd3; dest_reg = 5'd9;
        step();
        busy_cycles = busy ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            enable = 1'b1; result_sel = 3'd1; dest_reg = 5'd4; alu_result = 32'hBAD0_0000 + i;
            div_done = (i == 4);
            step();
            if (busy) busy_cycles++;
            chk("mul_wait_we", rf_we, 0);
        end
        idle_inputs();
        mul_done = 1'b1; mul_result = 32'hDEAD_BEEF;
        step();
        chk("mul_busy_cycles", busy_cycles, 11);
        chk("mul_done_we", rf_we, 1);
        chk("mul_done_waddr", rf_waddr, 9);
        chk("mul_done_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("mul_done_busy", busy, 0);
        idle_inputs();
        step();
        chk("mul_after_we", rf_we, 0);
        chk("mul_after_wdata", rf_wdata, 32'hDEAD_BEEF);

        // Divider never completes; a stray mul_done mid-wait must not complete it.
        enable = 1'b1; result_sel = 3'd2; dest_reg = 5'd7;
        step();
        idle_inputs();
        for (int i = 0; i < 63; i++) begin
            mul_done = (i == 30); mul_result = 32'h0BAD_0BAD;
            step();
            if (!busy || rf_we || timeout_err) chk("div_wait_state", {busy, rf_we, timeout_err}, 3'b100);
        end
        idle_inputs();
        step();
        chk("to_terr", timeout_err, 1);
        chk("to_busy", busy, 0);
        chk("to_we", rf_we, 0);
        enable = 1'b1; result_sel = 3'd1; dest_reg = 5'd2; alu_result = 32'hCAFE_0001;
        step();
        idle_inputs();
        chk("to_post_we", rf_we, 1);
        step(); step();
        chk("to_sticky", timeout_err, 1);

        // Reset abandons an in-progress divide.
        enable = 1'b1; result_sel = 3'd2; dest_reg = 5'd7;
        step();
        idle_inputs();
        step(); step();
        reset = 1'b1;
        step();
        chk("rstw_we", rf_we, 0);
        chk("rstw_waddr", rf_waddr, 0);
        chk("rstw_wdata", rf_wdata, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_terr", timeout_err, 0);
        reset = 1'b0;
        div_done = 1'b1; div_result = 32'h1357_9BDF;
        step();
        idle_inputs();
        chk("rstw_late_done_we", rf_we, 0);

        // Completion coincident with the final counted cycle wins over the timeout.
        enable = 1'b1; result_sel = 3'd3; dest_reg = 5'd12;
        step();
        idle_inputs();
        for (int i = 0; i < 63; i++) step();
        chk("edge_busy", busy, 1);
        mul_done = 1'b1; mul_result = 32'h0F0F_F0F0;
        step();
        idle_inputs();
        chk("edge_we", rf_we, 1);
        chk("edge_wdata", rf_wdata, 32'h0F0F_F0F0);
        chk("edge_terr", timeout_err, 0);

        // Randomized traffic against the model.
        reset = 1'b1;
        step();
        model_reset();
        reset = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset          = ($urandom_range(0, 499) == 0);
            enable         = ($urandom_range(0, 3) != 0);
            result_sel     = 3'($urandom_range(0, 7));
            dest_reg       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            alu_result     = $urandom;
            shifter_result = $urandom;
            mul_result     = $urandom;
            div_result     = $urandom;
            if (((cyc / 300) % 4) == 3) begin
                mul_done = 1'b0; div_done = 1'b0;
            end else begin
                mul_done = ($urandom_range(0, 9) == 0);
                div_done = ($urandom_range(0, 9) == 0);
            end
            model_step();
            step();
            chk("rnd_we", rf_we, e_we);
            chk("rnd_waddr", rf_waddr, e_addr);
            chk("rnd_wdata", rf_wdata, e_data);
            chk("rnd_busy", busy, m_unit != 0);
            chk("rnd_terr", timeout_err, e_terr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
